// File: rtl/imm_gen_stage_pkg.sv
// Shared definitions for the immediate-generation stage: format codes,
// RV opcode constants and the sign-extension helper.
package imm_gen_stage_pkg;

    typedef enum logic [2:0] {
        FMT_NULL = 3'd0,
        FMT_I    = 3'd1,
        FMT_U    = 3'd2,
        FMT_J    = 3'd3,
        FMT_S    = 3'd4,
        FMT_B    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_OPIMM   = 7'b0010011;
    localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

    // Immediates are assembled at 32 bits; callers truncate to their XLEN.
    function automatic logic [63:0] sext_to64(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/imm_gen_stage_imm_decode.sv
// Combinational immediate decoder: opcode selects the format, the
// immediate is assembled and extended to XLEN.
module imm_decode
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit EN_ZIMM = 1'b1
) (
    input  logic [31:0]     inst,
    output logic [2:0]      itype,
    output logic [XLEN-1:0] imm
);

    imm_fmt_e    fmt;
    logic [31:0] imm32;

    always_comb begin
        fmt   = FMT_NULL;
        imm32 = '0;
        case (inst[6:0])
            OP_LUI, OP_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {inst[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt   = FMT_J;
                imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_OPIMM: begin
                fmt   = FMT_I;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            OP_OPIMM32: begin
                // The W-form immediates only exist on RV64.
                if (XLEN == 64) begin
                    fmt   = FMT_I;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OP_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_SYSTEM: begin
                if (EN_ZIMM && inst[14]) begin
                    fmt   = FMT_Z;
                    imm32 = {27'b0, inst[19:15]};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        itype = fmt;
        imm   = XLEN'(sext_to64(imm32));
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a one-entry skid buffer;
// decodes on the input side and precomputes pc + imm.
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit EN_ZIMM = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_itype,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_target,
    output logic [31:0]     out_inst
);

    logic [2:0]      dec_itype;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;

    imm_decode #(.XLEN(XLEN), .EN_ZIMM(EN_ZIMM)) u_imm_decode (
        .inst  (in_inst),
        .itype (dec_itype),
        .imm   (dec_imm)
    );

    assign dec_target = in_pc + dec_imm;

    logic            out_valid_q,  out_valid_d;
    logic [2:0]      out_itype_q,  out_itype_d;
    logic [XLEN-1:0] out_imm_q,    out_imm_d;
    logic [XLEN-1:0] out_pc_q,     out_pc_d;
    logic [XLEN-1:0] out_target_q, out_target_d;
    logic [31:0]     out_inst_q,   out_inst_d;

    logic            skid_valid_q,  skid_valid_d;
    logic [2:0]      skid_itype_q,  skid_itype_d;
    logic [XLEN-1:0] skid_imm_q,    skid_imm_d;
    logic [XLEN-1:0] skid_pc_q,     skid_pc_d;
    logic [XLEN-1:0] skid_target_q, skid_target_d;
    logic [31:0]     skid_inst_q,   skid_inst_d;

    logic accept;
    logic emit;
    logic out_free;

    assign in_ready = rst & ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign emit     = out_valid_q & out_ready;
    assign out_free = ~out_valid_q | emit;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_itype_d   = out_itype_q;
        out_imm_d     = out_imm_q;
        out_pc_d      = out_pc_q;
        out_target_d  = out_target_q;
        out_inst_d    = out_inst_q;
        skid_valid_d  = skid_valid_q;
        skid_itype_d  = skid_itype_q;
        skid_imm_d    = skid_imm_q;
        skid_pc_d     = skid_pc_q;
        skid_target_d = skid_target_q;
        skid_inst_d   = skid_inst_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            // A full skid blocks in_ready, so skid refill and accept never collide.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_itype_d  = skid_itype_q;
                out_imm_d    = skid_imm_q;
                out_pc_d     = skid_pc_q;
                out_target_d = skid_target_q;
                out_inst_d   = skid_inst_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d  = 1'b1;
                out_itype_d  = dec_itype;
                out_imm_d    = dec_imm;
                out_pc_d     = in_pc;
                out_target_d = dec_target;
                out_inst_d   = in_inst;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d  = 1'b1;
            skid_itype_d  = dec_itype;
            skid_imm_d    = dec_imm;
            skid_pc_d     = in_pc;
            skid_target_d = dec_target;
            skid_inst_d   = in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q   <= 1'b0;
            out_itype_q   <= FMT_NULL;
            out_imm_q     <= '0;
            out_pc_q      <= '0;
            out_target_q  <= '0;
            out_inst_q    <= '0;
            skid_valid_q  <= 1'b0;
            skid_itype_q  <= FMT_NULL;
            skid_imm_q    <= '0;
            skid_pc_q     <= '0;
            skid_target_q <= '0;
            skid_inst_q   <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_itype_q   <= out_itype_d;
            out_imm_q     <= out_imm_d;
            out_pc_q      <= out_pc_d;
            out_target_q  <= out_target_d;
            out_inst_q    <= out_inst_d;
            skid_valid_q  <= skid_valid_d;
            skid_itype_q  <= skid_itype_d;
            skid_imm_q    <= skid_imm_d;
            skid_pc_q     <= skid_pc_d;
            skid_target_q <= skid_target_d;
            skid_inst_q   <= skid_inst_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_itype  = out_itype_q;
    assign out_imm    = out_imm_q;
    assign out_pc     = out_pc_q;
    assign out_target = out_target_q;
    assign out_inst   = out_inst_q;

endmodule
